// File: rtl/fifo_ctrl_status_if.sv
// Handshake and status bundle between a FIFO user and the pointer/status controller.
// The master is the producer/consumer side; the slave is the controller.
interface fifo_ctrl_status_if #(
  parameter int ADDR_WIDTH = 2
);
  logic                  wr;
  logic                  rd;
  logic                  flush;
  logic                  clr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, flush, clr_err,
    input  wr_en, w_addr, r_addr, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr, rd, flush, clr_err,
    output wr_en, w_addr, r_addr, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_status.sv
// Pointer, occupancy and status controller for a register-file FIFO.
// Only wr_en is combinational; every other output is registered from the next-state values.
module fifo_ctrl_status #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THR     = 2**ADDR_WIDTH - 1,
  parameter int AE_THR     = 1
) (
  input logic              clk,
  input logic              reset,
  fifo_ctrl_status_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THR[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] w_ptr_reg, w_ptr_next;
  logic [ADDR_WIDTH-1:0] r_ptr_reg, r_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  empty_reg, full_reg;
  logic                  almost_empty_reg, almost_full_reg;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  wr_acc, rd_acc;

  // A write into a full FIFO is still taken when a pop frees the head slot at the same edge.
  assign wr_acc = bus.wr & (~full_reg | bus.rd);
  assign rd_acc = bus.rd & ~empty_reg;

  always_comb begin
    w_ptr_next = w_ptr_reg + ADDR_WIDTH'(wr_acc);
    r_ptr_next = r_ptr_reg + ADDR_WIDTH'(rd_acc);
    count_next = count_reg + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    if (bus.flush) begin
      w_ptr_next = '0;
      r_ptr_next = '0;
      count_next = '0;
    end
  end

  // Error detection looks at the raw requests, so it still fires in a flush cycle.
  always_comb begin
    overflow_next  = (bus.wr & full_reg & ~bus.rd) | (overflow_reg & ~bus.clr_err);
    underflow_next = (bus.rd & empty_reg) | (underflow_reg & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_reg        <= '0;
      r_ptr_reg        <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      w_ptr_reg        <= w_ptr_next;
      r_ptr_reg        <= r_ptr_next;
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == DEPTH);
      almost_empty_reg <= (count_next <= AE_LVL);
      almost_full_reg  <= (count_next >= AF_LVL);
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  assign bus.wr_en        = wr_acc & ~bus.flush;
  assign bus.w_addr       = w_ptr_reg;
  assign bus.r_addr       = r_ptr_reg;
  assign bus.count        = count_reg;
  assign bus.empty        = empty_reg;
  assign bus.full         = full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl_status.sv
// Bench for fifo_ctrl_status: directed sequence then random traffic against a queue-based model.
// A small storage array driven by wr_en/w_addr lets the head entry be checked through r_addr.
module tb_fifo_ctrl_status;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_status_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl_status #(.ADDR_WIDTH(AW), .AF_THR(AF), .AE_THR(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [DEPTH];
  logic [7:0] wdata;
  always @(posedge clk) if (bus.wr_en) mem[bus.w_addr] <= wdata;

  // Reference model: FIFO contents as a queue, pointers as wrapping totals
  logic [7:0] q[$];
  int w_tot, r_tot;
  bit ovf_m, unf_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = q.size();
    check_val("count", int'(bus.count), sz);
    check_val("w_addr", int'(bus.w_addr), w_tot % DEPTH);
    check_val("r_addr", int'(bus.r_addr), r_tot % DEPTH);
    check_val("empty", int'(bus.empty), int'(sz == 0));
    check_val("full", int'(bus.full), int'(sz == DEPTH));
    check_val("almost_full", int'(bus.almost_full), int'(sz >= AF));
    check_val("almost_empty", int'(bus.almost_empty), int'(sz <= AE));
    check_val("overflow", int'(bus.overflow), int'(ovf_m));
    check_val("underflow", int'(bus.underflow), int'(unf_m));
    if (sz > 0) check_val("head", int'(mem[bus.r_addr]), int'(q[0]));
    $display("cyc t=%0t wr=%0b rd=%0b fl=%0b clr=%0b -> count=%0d w=%0d r=%0d e=%0b f=%0b ovf=%0b unf=%0b",
             $time, bus.wr, bus.rd, bus.flush, bus.clr_err, bus.count, bus.w_addr, bus.r_addr,
             bus.empty, bus.full, bus.overflow, bus.underflow);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    @(posedge clk);
    q.delete(); w_tot = 0; r_tot = 0; ovf_m = 1'b0; unf_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("wr_en_idle", int'(bus.wr_en), 0);
    check_state();
  endtask

  // Called just after a falling edge: drive, check wr_en, clock, update model, check state.
  task automatic cycle(input bit w, input bit r, input bit fl, input bit clr, input logic [7:0] d);
    bit was_full, was_empty, w_acc, r_acc;
    bus.wr = w; bus.rd = r; bus.flush = fl; bus.clr_err = clr; wdata = d;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    w_acc = w && (!was_full || r);
    r_acc = r && !was_empty;
    #1;
    check_val("wr_en", int'(bus.wr_en), int'(w_acc && !fl));
    @(posedge clk);
    ovf_m = (w && was_full && !r) || (ovf_m && !clr);
    unf_m = (r && was_empty) || (unf_m && !clr);
    if (fl) begin
      q.delete(); w_tot = 0; r_tot = 0;
    end else begin
      if (r_acc) begin void'(q.pop_front()); r_tot++; end
      if (w_acc) begin q.push_back(d); w_tot++; end
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    reset = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    wdata = '0;
    @(negedge clk);
    do_reset();

    // Fill, then an overflowing write
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'hA1 + 8'(i));
    check_val("head_a1", int'(mem[bus.r_addr]), 8'hA1);
    cycle(1, 0, 0, 0, 8'hA5);
    check_val("ovf_after_fifth", int'(bus.overflow), 1);

    // Full with simultaneous read and write
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 8'hB0 + 8'(i));
    check_val("head_a4", int'(mem[bus.r_addr]), 8'hA4);

    // Drain, then rd&wr on empty
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'hC1);
    check_val("unf_set", int'(bus.underflow), 1);
    cycle(0, 1, 0, 0, 8'h00);

    // Set beats clear on overflow
    cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'hD0 + 8'(i));
    cycle(1, 0, 0, 1, 8'hDF);
    check_val("ovf_set_wins", int'(bus.overflow), 1);
    cycle(0, 0, 0, 1, 8'h00);
    check_val("ovf_cleared", int'(bus.overflow), 0);

    // Flush at count 3 with a write
    cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 0, 1, 0, 8'hE1);
    check_val("flush_count", int'(bus.count), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 10, 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_status.md
# fifo_ctrl_status

Pointer and status controller for the register-file FIFO. It generates the write/read addresses and write enable that drive the `reg_file` storage array. It tracks occupancy and produces full/empty, programmable almost-full/almost-empty, and sticky overflow/underflow error flags. Together with `reg_file` it forms the synchronous FIFO used by the FtMcs data paths.

## Interface
- `ADDR_WIDTH`, 2: address bits; depth = 2**ADDR_WIDTH.
- `AF_THR`, 2**ADDR_WIDTH-1: almost_full asserts when count >= AF_THR; legal 1..2**ADDR_WIDTH.
- `AE_THR`, 1: almost_empty asserts when count <= AE_THR; legal 0..2**ADDR_WIDTH-1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr`  in  1  write request from producer.
- `rd`  in  1  read request (pop) from consumer.
- `flush`  in  1  synchronous clear of pointers/count; error flags kept.
- `clr_err`  in  1  clears sticky overflow/underflow.
- `wr_en`  out  1  combinational write enable to storage (accepted write).
- `w_addr`  out  ADDR_WIDTH  write pointer to storage.
- `r_addr`  out  ADDR_WIDTH  read pointer to storage (head entry).
- `count`  out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH.
- `empty`, `full`  out  1  registered status.
- `almost_empty`, `almost_full`  out  1  registered threshold status.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Acceptance (combinational on current state):
  - wr_acc = wr & (~full | rd)
  - rd_acc = rd & ~empty
  - wr_en = wr_acc & ~flush
- Simultaneous events:
  - Full with rd & wr: both accepted, count unchanged, full stays 1. Storage reads the old head combinationally and overwrites it at the edge.
  - Empty with rd & wr: only the write is accepted; underflow is set.
- Next-state updates:
  - w_ptr += wr_acc and r_ptr += rd_acc, each mod 2**ADDR_WIDTH; wrap-around is natural.
  - count += wr_acc − rd_acc.
- Status flags, all derived from the next count and registered:
  - empty = (count==0)
  - full = (count==2**ADDR_WIDTH)
  - almost_full = (count>=AF_THR)
  - almost_empty = (count<=AE_THR)
- Error flags:
  - overflow sets on wr & full & ~rd.
  - underflow sets on rd & empty.
  - Both hold until clr_err or reset.
  - Set has priority over clr_err in the same cycle.
- flush:
  - Pointers and count go to 0 and flags go to their reset values.
  - flush overrides rd/wr in that cycle: wr_en=0 and no pointer advance.
  - Error detection still applies to that cycle's rd/wr.
- Priority: reset > flush > rd/wr.

## Timing
- Reset values:
  - w_addr=0, r_addr=0, count=0
  - empty=1, full=0, almost_full=0
  - almost_empty=1 (AE_THR>=0)
  - overflow=0, underflow=0
- Reset applies at the rising edge while `reset`=1. Reset mid-operation discards all contents in one cycle.
- wr_en is same-cycle combinational; data is written at that edge.
- All other outputs change only at rising edges and reflect the post-edge state.
- The write-to-read view has one-cycle latency: an entry written at edge N is visible on r_addr/storage output and empty=0 after edge N.
- Pop semantics: the head is valid while empty=0. Asserting rd consumes it at the next edge.
- Status is never combinational from rd/wr; only wr_en is.

## Test plan
Parameters: ADDR_WIDTH=2, AF_THR=3, AE_THR=1.

1. Reset with wr=rd=0 -> empty=1, almost_empty=1, full=0, count=0, w_addr=r_addr=0, wr_en=0.
2. Four writes of 0xA1..0xA4, then a fifth wr with rd=0:
   - count sequence 1,2,3,4; almost_full asserts at count 3; full=1 at 4.
   - Fifth wr gives wr_en=0 and overflow=1; w_addr wraps to 0.
3. From full, rd&wr together for 3 cycles:
   - wr_en=1 each cycle, count=4 and full=1 throughout.
   - r_addr 0->1->2->3; heads read 0xA1,0xA2,0xA3.
4. Empty FIFO, rd=1 with wr=1:
   - wr_en=1, underflow=1, r_addr unchanged, count=1.
   - Next cycle rd alone -> count=0, empty=1.
5. Overflow=1 with clr_err=1 and a coincident overflowing wr -> overflow stays 1. Next cycle clr_err=1 alone -> overflow=0.
6. count=3 with flush=1 and wr=1 in the same cycle:
   - Next cycle count=0, pointers 0, empty=1.
   - wr_en=0 during flush; error flags are unchanged.
